// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// oversampling ratio, default frame parameters and a counter-width helper.
package uart_pkg;

  // The line is oversampled 16x. Each data or start bit lasts OSR ticks.
  localparam int OSR             = 16;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Width of a counter that indexes n items. Never returns less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read-side handshake between the byte FIFO and the transmitter.
// The FIFO is first-word-fall-through, so r_data is valid while empty = 0.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            empty;
  logic [DBIT-1:0] r_data;
  logic            rd;

  // The transmitter initiates pops.
  modport master (input empty, input r_data, output rd);
  // The FIFO answers them.
  modport slave  (output empty, output r_data, input rd);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator. It counts 0..DVSR-1 and flags the last count.
// It is held at zero while clr_i is high, so every frame starts on a clean
// tick boundary.
module uart_baud_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  logic [DVSR_W-1:0] d_q;
  logic [DVSR_W-1:0] d_d;

  assign tick_o = (d_q == DVSR_W'(DVSR - 1));

  // Next count: hold at zero while cleared, wrap after the tick, else increment.
  always_comb begin
    // NOTE: assign a default first so that every path drives d_d and no latch is inferred.
    d_d = d_q;
    if (clr_i || tick_o) begin
      d_d = '0;
    end else begin
      d_d = d_q + DVSR_W'(1);
    end
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that all registers update together at the edge.
    if (reset) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter. It pops one word from a FWFT FIFO whenever it
// is idle and the FIFO is not empty, and serialises the word LSB-first with
// a start bit and an SB_TICK-tick stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_if.master        fifo,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int N_W = cnt_width(DBIT);

  state_e          state_q;
  logic [4:0]      s_q;
  logic [N_W-1:0]  n_q;
  logic [DBIT-1:0] b_q;
  logic            tx_q;

  logic            tick;
  logic            fifo_rd;
  logic [DBIT-1:0] b_shift;
  logic            s_bit_last;
  logic            s_stop_last;
  logic            n_last;

  // The divider only runs while a frame is on the line.
  uart_baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  // Pop strobe. It is gated by reset so that a word is never taken while the
  // FSM is being forced back to IDLE.
  assign fifo_rd = (state_q == ST_IDLE) & ~fifo.empty & ~reset;
  assign fifo.rd = fifo_rd;

  assign b_shift     = b_q >> 1;
  assign s_bit_last  = (s_q == 5'(OSR - 1));
  assign s_stop_last = (s_q == 5'(SB_TICK - 1));
  assign n_last      = (n_q == N_W'(DBIT - 1));

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = (state_q == ST_STOP) & tick & s_stop_last;

  // Frame FSM. tx_q is loaded with the level of the state being entered, so
  // the line changes in the same cycle that the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      s_q     <= '0;
      n_q     <= '0;
      // NOTE: the shift register is reset only because it is cheap here; it is always reloaded before use.
      b_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo.empty) begin
            b_q     <= fifo.r_data;
            s_q     <= '0;
            n_q     <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (s_bit_last) begin
              s_q     <= '0;
              tx_q    <= b_q[0];
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (s_bit_last) begin
              s_q <= '0;
              b_q <= b_shift;
              if (n_last) begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                n_q  <= n_q + N_W'(1);
                tx_q <= b_shift[0];
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (s_stop_last) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with DVSR=4 (64 clocks per bit). DUT A uses a
// 16-tick stop bit and DUT B a 32-tick stop bit. Each DUT is fed by a small
// FWFT FIFO model.
module tb_uart_tx;

  localparam int BIT = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_if #(.DBIT(8)) ifa ();
  uart_tx_if #(.DBIT(8)) ifb ();

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(8)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .fifo         (ifa),
    .tx           (tx_a),
    .tx_busy      (busy_a),
    .tx_done_tick (done_a)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(4), .DVSR_W(8)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .fifo         (ifb),
    .tx           (tx_b),
    .tx_busy      (busy_b),
    .tx_done_tick (done_b)
  );

  // FIFO models. The write pointers are driven only by the stimulus and the
  // read pointers only by the pop strobes. Reset does not touch the FIFO.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] wr_a = '0, rd_a = '0;
  logic [7:0] wr_b = '0, rd_b = '0;

  assign ifa.empty  = (wr_a == rd_a);
  assign ifa.r_data = mem_a[rd_a];
  assign ifb.empty  = (wr_b == rd_b);
  assign ifb.r_data = mem_b[rd_b];

  always @(posedge clk) if (ifa.rd) rd_a <= rd_a + 8'd1;
  always @(posedge clk) if (ifb.rd) rd_b <= rd_b + 8'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);   return (sel != 0) ? tx_b   : tx_a;   endfunction
  function automatic logic get_busy(input int sel); return (sel != 0) ? busy_b : busy_a; endfunction
  function automatic logic get_done(input int sel); return (sel != 0) ? done_b : done_a; endfunction
  function automatic logic get_rd(input int sel);   return (sel != 0) ? ifb.rd : ifa.rd; endfunction
  function automatic logic get_empty(input int sel); return (sel != 0) ? ifb.empty : ifa.empty; endfunction

  task automatic push(input int sel, input logic [7:0] d);
    if (sel != 0) begin
      mem_b[wr_b] = d;
      wr_b = wr_b + 8'd1;
    end else begin
      mem_a[wr_a] = d;
      wr_a = wr_a + 8'd1;
    end
  endtask

  // Returns at the falling edge of the pop cycle t.
  task automatic wait_pop(input string tag, input int sel);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_rd(sel) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_pop"}, found, 1'b1);
    check({tag, "_tx_at_pop"}, get_tx(sel), 1'b1);
  endtask

  // Called at the falling edge of pop cycle t. It checks each bit window
  // cycle by cycle, the done-pulse position and the return to IDLE at the
  // end of the frame. It leaves the caller at the falling edge of cycle
  // t + frame + 1 and reports the pop strobe seen there.
  task automatic check_frame(input string tag, input int sel, input logic [7:0] data,
                             input int stop_clks, output logic rd_next);
    logic [9:0] fr;
    logic       obs;
    logic       busy_ok;
    int         k, len, done_at, done_cnt, rd_seen;
    fr = {1'b1, data, 1'b0};
    k = 0; done_at = -1; done_cnt = 0; rd_seen = 0; busy_ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      len = (b == 9) ? stop_clks : BIT;
      obs = fr[b];
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        k++;
        if (get_tx(sel) !== fr[b]) obs = get_tx(sel);
        if (get_done(sel) === 1'b1) begin
          done_cnt++;
          if (done_at < 0) done_at = k;
        end
        if (get_rd(sel) !== 1'b0) rd_seen++;
        if (get_busy(sel) !== 1'b1) busy_ok = 1'b0;
      end
      check($sformatf("%s_bit%0d", tag, b), obs, fr[b]);
    end
    check({tag, "_done_at"},  done_at, 9 * BIT + stop_clks);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_rd_in_frame"}, rd_seen, 0);
    check({tag, "_busy_frame"}, busy_ok, 1'b1);
    @(negedge clk);
    check({tag, "_idle_tx"},   get_tx(sel), 1'b1);
    check({tag, "_idle_busy"}, get_busy(sel), 1'b0);
    rd_next = get_rd(sel);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    logic rd_next;
    int   rd_cnt, bad_tx, bad_busy;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx",   tx_a,   1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_rd",   ifa.rd, 1'b0);
    reset = 1'b0;

    // Empty FIFO for 1000 clocks.
    rd_cnt = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifa.rd !== 1'b0) rd_cnt++;
      if (tx_a !== 1'b1) bad_tx++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    check("empty_rd",   rd_cnt,   0);
    check("empty_tx",   bad_tx,   0);
    check("empty_busy", bad_busy, 0);

    // Single byte 0xA5.
    @(posedge clk); #1;
    push(0, 8'hA5);
    wait_pop("a5", 0);
    check_frame("a5", 0, 8'hA5, 16 * 4, rd_next);
    check("a5_no_repop", rd_next, 1'b0);
    check("a5_fifo_empty", get_empty(0), 1'b1);

    // Burst of three bytes with a continuously non-empty FIFO.
    @(posedge clk); #1;
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    wait_pop("b0", 0);
    check_frame("b0", 0, 8'h00, 64, rd_next);
    check("b0_gap641", rd_next, 1'b1);
    check_frame("b1", 0, 8'hFF, 64, rd_next);
    check("b1_gap641", rd_next, 1'b1);
    check_frame("b2", 0, 8'h3C, 64, rd_next);
    check("b2_no_repop", rd_next, 1'b0);

    // Mid-frame reset during the third data bit of 0x55.
    @(posedge clk); #1;
    push(0, 8'h55); push(0, 8'h81);
    wait_pop("mr", 0);
    repeat (202) @(negedge clk);
    check("mr_bit2", tx_a, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mr_tx",   tx_a,   1'b1);
    check("mr_busy", busy_a, 1'b0);
    check("mr_rd_gated", ifa.rd, 1'b0);
    reset = 1'b0;
    #1;
    check("mr_repop", ifa.rd, 1'b1);
    check_frame("mr81", 0, 8'h81, 64, rd_next);
    check("mr_no_resend", rd_next, 1'b0);
    check("mr_fifo_empty", get_empty(0), 1'b1);

    // Reset held for five cycles with a non-empty FIFO.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    push(0, 8'h5A);
    rd_cnt = 0; bad_tx = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifa.rd !== 1'b0) rd_cnt++;
      if (tx_a !== 1'b1) bad_tx++;
    end
    check("rs_rd_held", rd_cnt, 0);
    check("rs_tx_held", bad_tx, 0);
    reset = 1'b0;
    #1;
    check("rs_first_pop", ifa.rd, 1'b1);
    check_frame("rs5a", 0, 8'h5A, 64, rd_next);
    check("rs_no_repop", rd_next, 1'b0);

    // Two-stop-bit length on DUT B.
    @(posedge clk); #1;
    push(1, 8'h01);
    wait_pop("sb32", 1);
    check_frame("sb32", 1, 8'h01, 128, rd_next);
    check("sb32_no_repop", rd_next, 1'b0);
    check("sb32_fifo_empty", get_empty(1), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
